// File: rtl/pulse_launch_queue.sv
// pulse_launch_queue: fast-domain initiator that queues event pulses and launches them into a busy-handshake synchronizer
module pulse_launch_queue #(
   parameter int CNT_W   = 4,
   parameter int BUSY_TO = 64
) (
   input  logic             clk_fast,
   input  logic             rst_n_fast,
   input  logic             ev_pulse,
   input  logic             sync_busy,
   input  logic             err_clr,
   output logic             sync_pulse,
   output logic [CNT_W-1:0] pend_cnt,
   output logic             in_flight,
   output logic             overflow,
   output logic             timeout_err
);

   localparam int               TMR_W    = $clog2(BUSY_TO + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(BUSY_TO - 1);
   localparam logic [TMR_W-1:0] TMR_SAT  = TMR_W'(BUSY_TO);

   typedef enum logic [1:0] {IDLE, WAIT_HI, WAIT_LO} state_t;

   state_t           state;
   logic [TMR_W-1:0] timer;
   logic             launch;
   logic             accept;
   logic             drop;
   logic             expire;

   // Per-edge decisions: a launch frees a slot, so a full counter still accepts a coincident event
   always_comb begin
      launch = (state == IDLE) && (pend_cnt != '0) && !sync_busy;
      accept = ev_pulse && ((pend_cnt != CNT_MAX) || launch);
      drop   = ev_pulse && !accept;
      expire = (timer == TMR_LAST) &&
               (((state == WAIT_HI) && !sync_busy) || ((state == WAIT_LO) && sync_busy));
   end

   // Pending counter, handshake FSM, wait timer and sticky error flags (set beats clear)
   always_ff @(posedge clk_fast or negedge rst_n_fast) begin
      if (!rst_n_fast) begin
         state       <= IDLE;
         timer       <= '0;
         pend_cnt    <= '0;
         sync_pulse  <= 1'b0;
         in_flight   <= 1'b0;
         overflow    <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         pend_cnt    <= pend_cnt + CNT_W'(accept) - CNT_W'(launch);
         sync_pulse  <= launch;
         overflow    <= drop || (overflow && !err_clr);
         timeout_err <= expire || (timeout_err && !err_clr);
         if ((state != IDLE) && (timer != TMR_SAT))
            timer <= timer + TMR_W'(1);
         case (state)
            IDLE:
               if (launch) begin
                  state     <= WAIT_HI;
                  in_flight <= 1'b1;
                  timer     <= '0;
               end
            WAIT_HI:
               if (sync_busy) begin
                  state <= WAIT_LO;
                  timer <= '0;
               end else if (expire) begin
                  state     <= IDLE;
                  in_flight <= 1'b0;
               end
            WAIT_LO:
               if (!sync_busy || expire) begin
                  state     <= IDLE;
                  in_flight <= 1'b0;
               end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
